// File: rtl/ks_voice_scheduler.sv
// Frame sequencer sharing one Karplus-Strong string engine across NUM_VOICES voices.
// Each falling LRCK edge starts a frame: issue every voice in order, sum the results, output a saturated mix.
//
// state  | meaning
// IDLE   | waiting for a falling LRCK edge
// ISSUE  | one-cycle engine command for voice_q
// WAIT   | engine busy; accumulate its sample on done
// OUTPUT | saturated mix visible with valid pulse
module ks_voice_scheduler #(
   parameter int NUM_VOICES = 4,
   parameter int VOICE_BITS = 2,
   parameter int DATA_WIDTH = 16,
   parameter int MIX_WIDTH  = DATA_WIDTH + VOICE_BITS
) (
   input  logic                  iCLK,
   input  logic                  iRST,
   input  logic                  iLRCK,
   input  logic [NUM_VOICES-1:0] iPluck,
   output logic                  oEng_start,
   output logic [VOICE_BITS-1:0] oEng_voice,
   output logic                  oEng_pluck,
   input  logic                  iEng_done,
   input  logic [DATA_WIDTH-1:0] iEng_sample,
   output logic [DATA_WIDTH-1:0] oSample,
   output logic                  oSample_valid,
   output logic                  oBusy,
   output logic                  oOverrun
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_OUTPUT} state_t;

   localparam logic signed [MIX_WIDTH-1:0] SAT_MAX =
      {{(MIX_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [MIX_WIDTH-1:0] SAT_MIN = ~SAT_MAX;
   localparam logic [VOICE_BITS-1:0] LAST_VOICE = VOICE_BITS'(NUM_VOICES-1);

   state_t                        state_q, state_d;
   logic                          lrck_q;
   logic [NUM_VOICES-1:0]         pending_q, pending_d;
   logic [VOICE_BITS-1:0]         voice_q, voice_d;
   logic signed [MIX_WIDTH-1:0]   acc_q, acc_d;
   logic [DATA_WIDTH-1:0]         sample_q, sample_d;
   logic                          valid_q, valid_d;
   logic                          overrun_q, overrun_d;

   logic                          tick;
   logic signed [MIX_WIDTH-1:0]   eng_ext;
   logic signed [MIX_WIDTH-1:0]   acc_sum;
   logic [DATA_WIDTH-1:0]         sat_val;
   logic [NUM_VOICES-1:0]         issue_sel;

   always_comb begin
      tick    = lrck_q & ~iLRCK;
      eng_ext = {{(MIX_WIDTH-DATA_WIDTH){iEng_sample[DATA_WIDTH-1]}}, iEng_sample};
      acc_sum = acc_q + eng_ext;

      if (acc_sum > SAT_MAX)
         sat_val = {1'b0, {(DATA_WIDTH-1){1'b1}}};
      else if (acc_sum < SAT_MIN)
         sat_val = {1'b1, {(DATA_WIDTH-1){1'b0}}};
      else
         sat_val = acc_sum[DATA_WIDTH-1:0];

      issue_sel = '0;
      for (int v = 0; v < NUM_VOICES; v++)
         if (voice_q == VOICE_BITS'(v)) issue_sel[v] = 1'b1;

      state_d    = state_q;
      voice_d    = voice_q;
      acc_d      = acc_q;
      sample_d   = sample_q;
      valid_d    = 1'b0;
      overrun_d  = overrun_q | (tick & (state_q != S_IDLE));
      oEng_start = 1'b0;
      oEng_pluck = 1'b0;
      pending_d  = pending_q | iPluck;

      case (state_q)
         S_IDLE: begin
            if (tick) begin
               state_d = S_ISSUE;
               voice_d = '0;
               acc_d   = '0;
            end
         end
         S_ISSUE: begin
            oEng_start = 1'b1;
            // a pluck arriving in this very cycle goes out now and stays queued
            oEng_pluck = |(issue_sel & (pending_q | iPluck));
            pending_d  = (pending_q & ~issue_sel) | iPluck;
            state_d    = S_WAIT;
         end
         S_WAIT: begin
            if (iEng_done) begin
               acc_d = acc_sum;
               if (voice_q == LAST_VOICE) begin
                  state_d  = S_OUTPUT;
                  sample_d = sat_val;
                  valid_d  = 1'b1;
               end else begin
                  state_d = S_ISSUE;
                  voice_d = voice_q + VOICE_BITS'(1);
               end
            end
         end
         S_OUTPUT: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         state_q   <= S_IDLE;
         lrck_q    <= 1'b0;
         pending_q <= '0;
         voice_q   <= '0;
         acc_q     <= '0;
         sample_q  <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         lrck_q    <= iLRCK;
         pending_q <= pending_d;
         voice_q   <= voice_d;
         acc_q     <= acc_d;
         sample_q  <= sample_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
      end
   end

   assign oEng_voice    = voice_q;
   assign oSample       = sample_q;
   assign oSample_valid = valid_q;
   assign oBusy         = (state_q != S_IDLE);
   assign oOverrun      = overrun_q;

endmodule

// File: tb/tb_ks_voice_scheduler.sv
// Scoreboard bench for ks_voice_scheduler: stimulus queues expected engine commands and mixes,
// a negedge monitor pops and compares them; a behavioural engine answers each command.
module tb_ks_voice_scheduler;

   localparam int ENG_L = 3;

   logic        iCLK, iRST, iLRCK;
   logic [3:0]  iPluck;
   logic        oEng_start, oEng_pluck, iEng_done;
   logic [1:0]  oEng_voice;
   logic [15:0] iEng_sample, oSample;
   logic        oSample_valid, oBusy, oOverrun;

   ks_voice_scheduler dut (
      .iCLK(iCLK), .iRST(iRST), .iLRCK(iLRCK), .iPluck(iPluck),
      .oEng_start(oEng_start), .oEng_voice(oEng_voice), .oEng_pluck(oEng_pluck),
      .iEng_done(iEng_done), .iEng_sample(iEng_sample),
      .oSample(oSample), .oSample_valid(oSample_valid),
      .oBusy(oBusy), .oOverrun(oOverrun)
   );

   typedef struct { int cyc; int voice; int pluck; } start_t;
   typedef struct { int cyc; int val; } samp_t;

   start_t exp_starts[$];
   samp_t  exp_samps[$];
   start_t s_pop;
   samp_t  o_pop;

   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   int   t0      = 0;
   int   frame_end = 0;
   int   eng_val[4];
   int   eng_extra[4];
   logic prev_start = 1'b0;

   initial iCLK = 1'b0;
   always #5 iCLK = ~iCLK;
   always @(posedge iCLK) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // monitor
   always @(negedge iCLK) begin
      if (iRST === 1'b0) begin
         if (oEng_start) begin
            check("start_gap", int'(prev_start), 0);
            if (exp_starts.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL unexpected_start: voice %0d at cycle %0d, expected none", oEng_voice, cyc);
            end else begin
               s_pop = exp_starts.pop_front();
               check("start_cycle", cyc, s_pop.cyc);
               check("start_voice", int'(oEng_voice), s_pop.voice);
               check("start_pluck", int'(oEng_pluck), s_pop.pluck);
            end
         end
         if (oSample_valid) begin
            if (exp_samps.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL unexpected_valid: sample %0d at cycle %0d, expected none", $signed(oSample), cyc);
            end else begin
               o_pop = exp_samps.pop_front();
               check("valid_cycle", cyc, o_pop.cyc);
               check("sample_value", int'($signed(oSample)), o_pop.val);
            end
         end
      end
      prev_start = oEng_start;
   end

   // engine model: done L (+extra) cycles after each start
   initial begin
      int v, lat;
      iEng_done = 1'b0;
      iEng_sample = '0;
      forever begin
         @(negedge iCLK);
         if (oEng_start === 1'b1 && iRST === 1'b0) begin
            v = int'(oEng_voice);
            lat = ENG_L + eng_extra[v];
            eng_extra[v] = 0;
            repeat (lat) @(posedge iCLK);
            #1;
            iEng_done = 1'b1;
            iEng_sample = eng_val[v][15:0];
            @(posedge iCLK);
            #1;
            iEng_done = 1'b0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1, "watchdog");
   end

   task automatic step(input int n);
      repeat (n) @(posedge iCLK);
      #1;
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) step(1);
   endtask

   task automatic tick_only();
      iLRCK = 1'b1;
      step(1);
      iLRCK = 1'b0;
   endtask

   task automatic start_frame(input int a, input int b, input int c, input int d,
                              input logic [3:0] pl, input int n_issue, input bit has_out,
                              input int exp_out, input int x0, input int x1, input int x2, input int x3);
      int ex[4];
      int rel;
      start_t st;
      samp_t so;
      eng_val[0] = a; eng_val[1] = b; eng_val[2] = c; eng_val[3] = d;
      ex[0] = x0; ex[1] = x1; ex[2] = x2; ex[3] = x3;
      for (int k = 0; k < 4; k++) eng_extra[k] = ex[k];
      tick_only();
      t0 = cyc;
      rel = 1;
      for (int k = 0; k < n_issue; k++) begin
         st.cyc = t0 + rel; st.voice = k; st.pluck = int'(pl[k]);
         exp_starts.push_back(st);
         rel += ENG_L + ex[k] + 1;
      end
      frame_end = t0 + rel;
      if (has_out) begin
         so.cyc = t0 + rel; so.val = exp_out;
         exp_samps.push_back(so);
      end
   endtask

   task automatic check_quiet(input string tag);
      @(negedge iCLK);
      check({tag, "_start"},   int'(oEng_start), 0);
      check({tag, "_voice"},   int'(oEng_voice), 0);
      check({tag, "_sample"},  int'(oSample), 0);
      check({tag, "_valid"},   int'(oSample_valid), 0);
      check({tag, "_busy"},    int'(oBusy), 0);
      check({tag, "_overrun"}, int'(oOverrun), 0);
      step(1);
   endtask

   initial begin
      iRST = 1'b1; iLRCK = 1'b0; iPluck = '0;
      for (int k = 0; k < 4; k++) begin eng_val[k] = 0; eng_extra[k] = 0; end
      step(2);
      iLRCK = 1'b1;
      check_quiet("rst");
      iLRCK = 1'b0;
      step(1);
      iRST = 1'b0;
      iLRCK = 1'b1;
      step(3);
      check_quiet("post_rst");

      // nominal mix, then hold check
      start_frame(100, 200, -50, 25, 4'b0000, 4, 1, 275, 0, 0, 0, 0);
      wait_until(frame_end + 10);
      @(negedge iCLK);
      check("hold_sample", int'($signed(oSample)), 275);
      check("hold_valid", int'(oSample_valid), 0);
      check("hold_busy", int'(oBusy), 0);
      step(1);

      // saturation and the exact upper boundary
      start_frame('h7000, 'h7000, 'h7000, 'h7000, 4'b0000, 4, 1, 32767, 0, 0, 0, 0);
      wait_until(frame_end + 3);
      start_frame(-28672, -28672, -28672, -28672, 4'b0000, 4, 1, -32768, 0, 0, 0, 0);
      wait_until(frame_end + 3);
      start_frame(16384, 16383, 0, 0, 4'b0000, 4, 1, 32767, 0, 0, 0, 0);
      wait_until(frame_end + 3);
      start_frame(-32768, -1, 0, 0, 4'b0000, 4, 1, -32768, 0, 0, 0, 0);
      wait_until(frame_end + 3);

      // pluck voice 2 after its issue: goes out next frame only
      start_frame(1, 2, 3, 4, 4'b0000, 4, 1, 10, 0, 0, 0, 0);
      wait_until(t0 + 11);
      iPluck = 4'b0100; step(1); iPluck = '0;
      wait_until(frame_end + 3);
      start_frame(1, 2, 3, 4, 4'b0100, 4, 1, 10, 0, 0, 0, 0);
      wait_until(frame_end + 3);
      start_frame(1, 2, 3, 4, 4'b0000, 4, 1, 10, 0, 0, 0, 0);
      wait_until(frame_end + 3);

      // pluck voice 1 inside its issue cycle: now and next frame
      start_frame(5, 6, 7, 8, 4'b0010, 4, 1, 26, 0, 0, 0, 0);
      wait_until(t0 + 5);
      iPluck = 4'b0010; step(1); iPluck = '0;
      wait_until(frame_end + 3);
      start_frame(5, 6, 7, 8, 4'b0010, 4, 1, 26, 0, 0, 0, 0);
      wait_until(frame_end + 3);
      start_frame(5, 6, 7, 8, 4'b0000, 4, 1, 26, 0, 0, 0, 0);
      wait_until(frame_end + 3);

      // overrun: stalled engine, dropped ticks, frame still completes once
      start_frame(10, 20, 30, 40, 4'b0000, 4, 1, 100, 500, 0, 0, 0);
      wait_until(t0 + 100);
      @(negedge iCLK);
      check("overrun_before", int'(oOverrun), 0);
      step(1);
      tick_only();
      step(2);
      @(negedge iCLK);
      check("overrun_set", int'(oOverrun), 1);
      check("overrun_busy", int'(oBusy), 1);
      step(1);
      wait_until(t0 + 400);
      tick_only();
      wait_until(frame_end + 5);
      @(negedge iCLK);
      check("overrun_sticky", int'(oOverrun), 1);
      step(1);
      start_frame(100, 200, -50, 25, 4'b0000, 4, 1, 275, 0, 0, 0, 0);
      wait_until(frame_end + 3);
      @(negedge iCLK);
      check("overrun_sticky2", int'(oOverrun), 1);
      step(1);

      // mid-frame reset while waiting on voice 2, with voice 3 pluck queued
      iPluck = 4'b1000; step(1); iPluck = '0; step(2);
      start_frame(1, 2, 3, 4, 4'b0000, 3, 0, 0, 0, 0, 20, 0);
      wait_until(t0 + 12);
      iRST = 1'b1;
      step(1);
      check_quiet("midrst");
      step(1);
      iRST = 1'b0;
      wait_until(t0 + 40);
      check_quiet("after_done");
      start_frame(100, 200, -50, 25, 4'b0000, 4, 1, 275, 0, 0, 0, 0);
      wait_until(frame_end + 5);

      check("starts_left", exp_starts.size(), 0);
      check("samples_left", exp_samps.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
